// File: rtl/duck_sprite_pkg.sv
// Shared types, screen constants and the generated asset ROM/palette contents
// for the duck sprite layer.
package duck_sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Asset ROM content: colour index is the nibble-sum of the address (mod 16).
  function automatic logic [3:0] rom_index(input logic [15:0] addr);
    return addr[3:0] + addr[7:4] + addr[11:8] + addr[15:12];
  endfunction

  function automatic rgb444_t palette_color(input logic [3:0] idx);
    rgb444_t c;
    c.r = idx;
    c.g = 4'hF - idx;
    c.b = idx + {idx[2:0], 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/duck_sprite_anim_ctrl.sv
// Animation sequencer: counts frame_start pulses while enabled and steps the
// sprite frame index every FRAME_HOLD pulses, wrapping after the last frame.
module duck_sprite_anim_ctrl #(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 8,
  parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               frame_start,
  input  logic               anim_en,
  output logic [FRAME_W-1:0] frame
);

  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;

  always_comb begin
    hold_next  = hold_reg;
    frame_next = frame_reg;
    if (frame_start && anim_en) begin
      if (hold_reg == HOLD_W'(FRAME_HOLD - 1)) begin
        hold_next  = '0;
        frame_next = (frame_reg == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_reg + 1'b1;
      end else begin
        hold_next = hold_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      hold_reg  <= '0;
      frame_reg <= '0;
    end else begin
      hold_reg  <= hold_next;
      frame_reg <= frame_next;
    end
  end

  assign frame = frame_reg;

endmodule

// File: rtl/duck_sprite_renderer.sv
// Positioned, power-of-2 scaled, animated sprite layer with RGB444 output.
// Optional macro DUCK_SPRITE_TRANSPARENCY_EN makes TRANSP_IDX pixels uncovered.
module duck_sprite_renderer
  import duck_sprite_pkg::*;
#(
  parameter int SPR_W      = 68,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int FRAME_HOLD = 8,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic               sprite_en,
  input  logic               flip_x,
  input  logic               anim_en,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               pixel_valid
);

  localparam int BOX_W     = SPR_W << SCALE_LOG2;
  localparam int BOX_H     = SPR_H << SCALE_LOG2;
  localparam int FRAME_PIX = SPR_W * SPR_H;
  localparam int ADDR_W    = $clog2(NUM_FRAMES * FRAME_PIX);
  localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int CW1       = COORD_W + 1;
`ifdef DUCK_SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  logic [COORD_W-1:0] sx_reg, sy_reg;
  logic               en_reg, flip_reg;
  logic [FRAME_W-1:0] frame;
  logic [CW1-1:0]     dx, dy;
  logic [COORD_W-1:0] lx, ly, lx_f;
  logic               hit, hit_reg, hit_d_reg, opaque;
  logic [ADDR_W-1:0]  addr_next, addr_reg;
  logic [IDX_W-1:0]   rom_q_reg;
  rgb444_t            pal [16];
  rgb444_t            rgb_reg;
  logic               valid_reg;

  duck_sprite_anim_ctrl #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FRAME_W    (FRAME_W)
  ) u_anim (
    .clk         (vga_clk),
    .srst        (reset),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .frame       (frame)
  );

  for (genvar gi = 0; gi < 16; gi++) begin : g_pal
    assign pal[gi] = palette_color(4'(gi));
  end

  // The extra MSB of dx/dy is the borrow: a pixel left of/above the box never wraps in.
  always_comb begin
    dx   = {1'b0, DrawX} - {1'b0, sx_reg};
    dy   = {1'b0, DrawY} - {1'b0, sy_reg};
    lx   = dx[COORD_W-1:0] >> SCALE_LOG2;
    ly   = dy[COORD_W-1:0] >> SCALE_LOG2;
    lx_f = flip_reg ? COORD_W'(SPR_W - 1) - lx : lx;
    hit  = en_reg && blank && !dx[COORD_W] && !dy[COORD_W]
           && (dx < CW1'(BOX_W)) && (dy < CW1'(BOX_H))
           && (DrawX < COORD_W'(SCREEN_W)) && (DrawY < COORD_W'(SCREEN_H));
    addr_next = ADDR_W'(frame) * ADDR_W'(FRAME_PIX)
              + ADDR_W'(ly) * ADDR_W'(SPR_W)
              + ADDR_W'(lx_f);
    opaque = hit_d_reg && (!TRANSP_EN || (rom_q_reg != IDX_W'(TRANSP_IDX)));
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sx_reg    <= '0;
      sy_reg    <= '0;
      en_reg    <= 1'b0;
      flip_reg  <= 1'b0;
      hit_reg   <= 1'b0;
      addr_reg  <= '0;
      rom_q_reg <= '0;
      hit_d_reg <= 1'b0;
      rgb_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (frame_start) begin
        sx_reg   <= sprite_x;
        sy_reg   <= sprite_y;
        en_reg   <= sprite_en;
        flip_reg <= flip_x;
      end
      hit_reg <= hit;
      if (hit) begin
        addr_reg <= addr_next;
      end
      // Registered ROM read, then palette lookup into the output register.
      rom_q_reg <= IDX_W'(rom_index(16'(addr_reg)));
      hit_d_reg <= hit_reg;
      valid_reg <= opaque;
      rgb_reg   <= opaque ? pal[4'(rom_q_reg)] : '0;
    end
  end

  assign red         = rgb_reg.r;
  assign green       = rgb_reg.g;
  assign blue        = rgb_reg.b;
  assign pixel_valid = valid_reg;

endmodule

// File: tb/tb_duck_sprite_renderer.sv
// Self-checking bench for duck_sprite_renderer: per-cycle scoreboard against a
// behavioural pixel model plus directed pixels with hand-computed colours.
module tb_duck_sprite_renderer;

  localparam int SW = 68;
  localparam int SH = 64;
  localparam int SC = 2;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic [9:0] DrawX, DrawY, sprite_x, sprite_y;
  logic       blank, frame_start, sprite_en, flip_x, anim_en;
  logic [3:0] red, green, blue;
  logic       pixel_valid;

  int checks = 0;
  int errors = 0;

  duck_sprite_renderer dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .sprite_en   (sprite_en),
    .flip_x      (flip_x),
    .anim_en     (anim_en),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .pixel_valid (pixel_valid)
  );

  always #5 vga_clk = ~vga_clk;

  // Palette colours written out by hand: r=i, g=15-i, b=3i mod 16.
  logic [11:0] pal_tab [16] = '{12'h0F0, 12'h1E3, 12'h2D6, 12'h3C9, 12'h4BC, 12'h5AF,
                                12'h692, 12'h785, 12'h878, 12'h96B, 12'hA5E, 12'hB41,
                                12'hC34, 12'hD27, 12'hE1A, 12'hF0D};

  // Model state: latched placement and number of animated frame_start pulses.
  int m_sx, m_sy, m_pulses;
  bit m_en, m_flip, armed;
  logic [12:0] pipe0, pipe1, exp_out;

  function automatic logic [12:0] model_px(int x, int y, bit bl);
    int dx, dy, lx, ly, addr, idx;
    dx = x - m_sx;
    dy = y - m_sy;
    if (!(m_en && bl && dx >= 0 && dy >= 0 && dx < SW * SC && dy < SH * SC && x < 640 && y < 480))
      return 13'h0;
    lx = dx / SC;
    ly = dy / SC;
    if (m_flip) lx = SW - 1 - lx;
    addr = ((m_pulses / 8) % 4) * SW * SH + ly * SW + lx;
    idx  = (addr % 16 + (addr / 16) % 16 + (addr / 256) % 16 + addr / 4096) % 16;
`ifdef DUCK_SPRITE_TRANSPARENCY_EN
    if (idx == 0) return 13'h0;
`endif
    return {1'b1, pal_tab[idx]};
  endfunction

  initial begin
    armed = 0;
    forever begin
      @(posedge vga_clk);
      if (reset) begin
        m_sx = 0; m_sy = 0; m_en = 0; m_flip = 0; m_pulses = 0;
        pipe0 = 0; pipe1 = 0; exp_out = 0; armed = 1;
      end else begin
        exp_out = pipe1;
        pipe1   = pipe0;
        pipe0   = model_px(int'(DrawX), int'(DrawY), blank);
        if (frame_start) begin
          m_sx = int'(sprite_x); m_sy = int'(sprite_y); m_en = sprite_en; m_flip = flip_x;
          if (anim_en) m_pulses++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge vga_clk);
      if (armed) begin
        checks++;
        if ({pixel_valid, red, green, blue} !== exp_out) begin
          errors++;
          $display("FAIL scoreboard t=%0t got %h expected %h", $time,
                   {pixel_valid, red, green, blue}, exp_out);
        end
      end
    end
  end

  task automatic check_out(input string name, input logic [12:0] want);
    checks++;
    if ({pixel_valid, red, green, blue} !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, {pixel_valid, red, green, blue}, want);
    end else begin
      $display("ok   %s = %h", name, want);
    end
  endtask

  // Present one pixel for one cycle, then read its result two edges later.
  task automatic pix(input int x, input int y, input bit bl, input logic [12:0] want,
                     input string name);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl;
    @(negedge vga_clk);
    blank = 1'b0;
    @(negedge vga_clk);
    @(negedge vga_clk);
    check_out(name, want);
  endtask

  task automatic pulse(input int x, input int y, input bit en, input bit fl, input bit an);
    sprite_x = 10'(x); sprite_y = 10'(y); sprite_en = en; flip_x = fl; anim_en = an;
    blank = 1'b0; frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  logic [12:0] c0, c2, c4, c7, c8, t0;

  initial begin
    c0 = {1'b1, 12'h0F0}; c2 = {1'b1, 12'h2D6}; c4 = {1'b1, 12'h4BC};
    c7 = {1'b1, 12'h785}; c8 = {1'b1, 12'h878};
`ifdef DUCK_SPRITE_TRANSPARENCY_EN
    t0 = 13'h0;
`else
    t0 = c0;
`endif
    reset = 1; DrawX = 0; DrawY = 0; blank = 0; frame_start = 0;
    sprite_x = 0; sprite_y = 0; sprite_en = 0; flip_x = 0; anim_en = 0;
    repeat (3) @(negedge vga_clk);
    reset = 0;
    check_out("reset_state", 13'h0);
    pix(100, 50, 1, 13'h0, "disabled_before_frame_start");

    pulse(100, 50, 1, 0, 0);
    pix(99, 50, 1, 13'h0, "left_of_box");
    pix(100, 50, 1, t0, "top_left_addr0");
    pix(235, 50, 1, c7, "right_col_lx67");
    pix(236, 50, 1, 13'h0, "past_right_edge");
    pix(100, 49, 1, 13'h0, "above_box");
    pix(100, 177, 1, c8, "bottom_row_ly63");
    pix(100, 178, 1, 13'h0, "below_box");
    pix(100, 50, 0, 13'h0, "blank_low_in_box");

    pulse(100, 50, 1, 1, 0);
    pix(100, 50, 1, c7, "flip_left_addr67");
    pix(235, 50, 1, t0, "flip_right_addr0");

    for (int i = 0; i < 8; i++) pulse(100, 50, 1, 0, 1);
    pix(100, 50, 1, c2, "anim_frame1");
    for (int i = 0; i < 8; i++) pulse(100, 50, 1, 0, 1);
    pix(100, 50, 1, c4, "anim_frame2");
    for (int i = 0; i < 24; i++) pulse(100, 50, 1, 0, 1);
    pix(100, 50, 1, c2, "anim_wrap_frame1");
    for (int i = 0; i < 5; i++) pulse(100, 50, 1, 0, 0);
    pix(100, 50, 1, c2, "anim_hold");
    for (int i = 0; i < 24; i++) pulse(100, 50, 1, 0, 1);
    pix(100, 50, 1, t0, "anim_back_frame0");

    sprite_x = 10'd600;
    pix(100, 50, 1, t0, "no_tearing_old_pos");
    pix(600, 50, 1, 13'h0, "no_tearing_new_pos");
    pulse(600, 50, 1, 0, 0);
    pix(600, 50, 1, t0, "clip_left_col");
    pix(639, 50, 1, c4, "clip_last_col");
    pix(20, 50, 1, 13'h0, "no_wrap_x20");
    pix(0, 50, 1, 13'h0, "no_wrap_x0");
    DrawY = 10'd60; blank = 1'b1;
    for (int x = 0; x < 640; x++) begin
      DrawX = 10'(x);
      @(negedge vga_clk);
    end
    blank = 1'b0;
    repeat (3) @(negedge vga_clk);

    for (int i = 0; i < 8; i++) pulse(100, 50, 1, 0, 1);
    DrawY = 10'd52; blank = 1'b1;
    for (int x = 90; x < 130; x++) begin
      DrawX = 10'(x);
      if (x == 110) begin
        reset = 1'b1; frame_start = 1'b1; sprite_en = 1'b1;
      end
      @(negedge vga_clk);
      if (x == 110) begin
        reset = 1'b0; frame_start = 1'b0;
        check_out("reset_mid_line_out", 13'h0);
      end
    end
    blank = 1'b0;
    repeat (3) @(negedge vga_clk);
    pix(100, 50, 1, 13'h0, "layer_off_after_reset");
    pulse(100, 50, 1, 0, 0);
    pix(100, 50, 1, t0, "frame0_after_reset");
    DrawY = 10'd80; blank = 1'b1;
    for (int x = 95; x < 240; x++) begin
      DrawX = 10'(x);
      @(negedge vga_clk);
    end
    blank = 1'b0;
    repeat (3) @(negedge vga_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
